// File: rtl/gate_controller_param_pkg.sv
// Shared state encodings and counter-width helper for the parking-gate
// controller family.
package gate_pkg;

    localparam logic [1:0] ST_CERRADO = 2'd0;
    localparam logic [1:0] ST_ABIERTO = 2'd1;
    localparam logic [1:0] ST_ALARMA  = 2'd2;
    localparam logic [1:0] ST_BLOQUEO = 2'd3;

    // Bits needed to hold 0..n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gate_controller_param_if.sv
// Lane-side bundle: vehicle/PIN inputs and gate status outputs.
interface gate_controller_param_if #(
    parameter int PIN_W     = 8,
    parameter int MAX_TRIES = 3
);
    localparam int CW = gate_pkg::cnt_w(MAX_TRIES);

    logic             Vehiculo;
    logic             Termino;
    logic             enterPin;
    logic [PIN_W-1:0] Pin;
    logic             Cerrado;
    logic             Abierto;
    logic             Alarma;
    logic             Bloqueo;
    logic [CW-1:0]    Intentos;

    modport master (
        output Vehiculo, Termino, enterPin, Pin,
        input  Cerrado, Abierto, Alarma, Bloqueo, Intentos
    );

    modport slave (
        input  Vehiculo, Termino, enterPin, Pin,
        output Cerrado, Abierto, Alarma, Bloqueo, Intentos
    );

endinterface

// File: rtl/gate_controller_param_open_timer.sv
// Open-gate dwell timer; flags the last allowed cycle in ABIERTO.
module open_timer
    import gate_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int TW = cnt_w(TIMEOUT);
    localparam logic [TW-1:0] LAST =
        (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    logic [TW-1:0] r_cnt;

    // Parks at LAST so the count can never wrap.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (TIMEOUT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/gate_controller_param.sv
// Parametrised single-lane gate controller: closed/open/alarm/block
// sequencing from vehicle presence, edge-qualified PIN entry and passage.
module gate_controller_param
    import gate_pkg::*;
#(
    parameter int               PIN_W     = 8,
    parameter logic [PIN_W-1:0] PIN_OK    = 8'h10,
    parameter int               MAX_TRIES = 3,
    parameter int               TIMEOUT   = 16
) (
    input logic Clk,
    input logic Reset,
    gate_controller_param_if.slave bus
);
    localparam int CW = cnt_w(MAX_TRIES);
    localparam logic [CW-1:0] TRIES_MAX = CW'(MAX_TRIES);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_tries;
    logic [CW-1:0] w_tries_nxt;
    logic [CW-1:0] w_tries_inc;
    logic          r_pin_q;
    logic          w_attempt;
    logic          w_good;
    logic          w_in_open;
    logic          w_expire;

    assign w_attempt   = bus.enterPin & ~r_pin_q;
    assign w_good      = (bus.Pin == PIN_OK);
    assign w_in_open   = (r_state == ST_ABIERTO);
    assign w_tries_inc = (r_tries == TRIES_MAX) ? r_tries
                                                : r_tries + 1'b1;

    open_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (Clk),
        .rst_n    (Reset),
        .i_clr    (~w_in_open),
        .i_en     (w_in_open),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tries_nxt = r_tries;
        unique case (r_state)
            ST_CERRADO: begin
                if (w_attempt && bus.Vehiculo) begin
                    if (w_good) begin
                        w_state_nxt = ST_ABIERTO;
                        w_tries_nxt = '0;
                    end else begin
                        w_tries_nxt = w_tries_inc;
                        if (w_tries_inc >= TRIES_MAX) begin
                            w_state_nxt = ST_ALARMA;
                        end
                    end
                end
            end
            ST_ALARMA: begin
                if (w_attempt) begin
                    if (w_good) begin
                        w_state_nxt = ST_ABIERTO;
                        w_tries_nxt = '0;
                    end else begin
                        w_tries_nxt = w_tries_inc;
                    end
                end
            end
            ST_ABIERTO: begin
                if (bus.Termino) begin
                    w_state_nxt = bus.Vehiculo ? ST_BLOQUEO
                                               : ST_CERRADO;
                end else if (w_expire) begin
                    w_state_nxt = ST_BLOQUEO;
                end
            end
            ST_BLOQUEO: begin
                if (w_attempt && w_good) begin
                    w_state_nxt = ST_ABIERTO;
                    w_tries_nxt = '0;
                end
            end
        endcase
    end

    // The button is tracked even in reset so a press held across
    // reset release is not mistaken for a fresh attempt.
    always_ff @(posedge Clk) begin
        r_pin_q <= bus.enterPin;
        if (!Reset) begin
            r_state <= ST_CERRADO;
            r_tries <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tries <= w_tries_nxt;
        end
    end

    assign bus.Cerrado  = (r_state != ST_ABIERTO);
    assign bus.Abierto  = (r_state == ST_ABIERTO);
    assign bus.Alarma   = (r_state == ST_ALARMA)
                        | (r_state == ST_BLOQUEO);
    assign bus.Bloqueo  = (r_state == ST_BLOQUEO);
    assign bus.Intentos = r_tries;

endmodule

// File: tb/tb_gate_controller_param.sv
// Bench: two lanes (TIMEOUT=8 and TIMEOUT=0) on shared stimulus,
// compared every cycle against a behavioural gate model.
module tb_gate_controller_param;

    localparam logic [7:0] GOOD = 8'h10;
    localparam int MAXT = 3;

    localparam int M_CLOSED = 0;
    localparam int M_OPEN   = 1;
    localparam int M_ALARM  = 2;
    localparam int M_BLOCK  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       veh, term, btn;
    logic [7:0] pin;

    int n_chk = 0;
    int n_err = 0;

    int m_st[2];
    int m_tries[2];
    int m_open[2];
    bit m_prev[2];
    int tmo[2];

    always #5 clk = ~clk;

    gate_controller_param_if #(.PIN_W(8), .MAX_TRIES(3)) b0 ();
    gate_controller_param_if #(.PIN_W(8), .MAX_TRIES(3)) b1 ();

    assign b0.Vehiculo = veh;
    assign b0.Termino  = term;
    assign b0.enterPin = btn;
    assign b0.Pin      = pin;
    assign b1.Vehiculo = veh;
    assign b1.Termino  = term;
    assign b1.enterPin = btn;
    assign b1.Pin      = pin;

    gate_controller_param #(
        .PIN_W(8), .PIN_OK(8'h10), .MAX_TRIES(3), .TIMEOUT(8)
    ) u_dut0 (
        .Clk(clk), .Reset(rst_n), .bus(b0.slave)
    );

    gate_controller_param #(
        .PIN_W(8), .PIN_OK(8'h10), .MAX_TRIES(3), .TIMEOUT(0)
    ) u_dut1 (
        .Clk(clk), .Reset(rst_n), .bus(b1.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    function automatic void go_open(input int k);
        m_st[k]    = M_OPEN;
        m_tries[k] = 0;
        m_open[k]  = 0;
    endfunction

    function automatic void model_step();
        bit att;
        bit good;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_st[k]    = M_CLOSED;
                m_tries[k] = 0;
                m_open[k]  = 0;
                m_prev[k]  = btn;
                continue;
            end
            att       = btn && !m_prev[k];
            m_prev[k] = btn;
            good      = (pin == GOOD);
            case (m_st[k])
                M_CLOSED:
                    if (att && veh) begin
                        if (good) go_open(k);
                        else begin
                            if (m_tries[k] < MAXT) m_tries[k]++;
                            if (m_tries[k] >= MAXT) m_st[k] = M_ALARM;
                        end
                    end
                M_ALARM:
                    if (att) begin
                        if (good) go_open(k);
                        else if (m_tries[k] < MAXT) m_tries[k]++;
                    end
                M_OPEN:
                    if (term) m_st[k] = veh ? M_BLOCK : M_CLOSED;
                    else if (tmo[k] > 0 && m_open[k] + 1 == tmo[k])
                        m_st[k] = M_BLOCK;
                    else m_open[k]++;
                default:
                    if (att && good) go_open(k);
            endcase
        end
    endfunction

    function automatic int exp_flags(input int st);
        case (st)
            M_CLOSED: return 4'b1000;
            M_OPEN:   return 4'b0100;
            M_ALARM:  return 4'b1010;
            default:  return 4'b1011;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("lane0_flags",
              {b0.Cerrado, b0.Abierto, b0.Alarma, b0.Bloqueo},
              exp_flags(m_st[0]));
        check("lane0_tries", int'(b0.Intentos), m_tries[0]);
        check("lane1_flags",
              {b1.Cerrado, b1.Abierto, b1.Alarma, b1.Bloqueo},
              exp_flags(m_st[1]));
        check("lane1_tries", int'(b1.Intentos), m_tries[1]);
    endtask

    task automatic press(input logic [7:0] p);
        pin = p;
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
    endtask

    task automatic close_lane();
        veh  = 1'b0;
        term = 1'b1;
        tick();
        term = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        tmo[0] = 8;
        tmo[1] = 0;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_CLOSED; m_tries[k] = 0;
            m_open[k] = 0; m_prev[k] = 1'b0;
        end
        rst_n = 1'b0; veh = 1'b0; term = 1'b0; btn = 1'b0; pin = '0;
        tick();
        tick();
        check("reset_cerrado", b0.Cerrado, 1);
        rst_n = 1'b1;
        tick();

        // normal passage
        veh = 1'b1;
        pin = GOOD; btn = 1'b1;
        tick();
        check("pass_open", b0.Abierto, 1);
        btn = 1'b0;
        close_lane();
        check("pass_closed", b0.Cerrado, 1);

        // alarm and saturation
        veh = 1'b1;
        repeat (4) press(8'hFF);
        check("alarm_on", b0.Alarma, 1);
        check("tries_sat", int'(b0.Intentos), 3);
        press(GOOD);
        check("alarm_clear", int'(b0.Intentos), 0);
        close_lane();

        // edge qualification
        veh = 1'b1; pin = 8'h00; btn = 1'b1;
        tick();
        pin = GOOD;
        tick(); tick();
        check("held_no_open", b0.Abierto, 0);
        btn = 1'b0; tick();
        btn = 1'b1; tick();
        check("repress_open", b0.Abierto, 1);
        btn = 1'b0;
        close_lane();

        // tailgate, block, recovery
        veh = 1'b1;
        press(GOOD);
        term = 1'b1; tick(); term = 1'b0;
        check("tailgate_block", b0.Bloqueo, 1);
        press(8'h55);
        check("block_bad_ign", b0.Bloqueo, 1);
        press(GOOD);
        check("block_exit", b0.Abierto, 1);
        close_lane();

        // timeout on lane0, none on lane1
        veh = 1'b1; pin = GOOD; btn = 1'b1;
        tick();
        btn = 1'b0; veh = 1'b0;
        n = 0;
        while (b0.Abierto && n < 50) begin
            n++;
            tick();
        end
        check("open_len", n, 8);
        check("tmo_block", b0.Bloqueo, 1);
        repeat (20) tick();
        check("no_tmo_open", b1.Abierto, 1);
        close_lane();
        press(GOOD);
        close_lane();

        // reset from open, then from alarm, with all inputs high
        veh = 1'b1;
        press(GOOD);
        rst_n = 1'b0; veh = 1'b1; term = 1'b1; btn = 1'b1; pin = GOOD;
        tick();
        check("rst_open", {b0.Cerrado, b0.Abierto}, 2'b10);
        rst_n = 1'b1; term = 1'b0;
        tick(); tick();
        check("held_thru_rst", b0.Abierto, 0);
        btn = 1'b0; tick();
        repeat (3) press(8'h01);
        rst_n = 1'b0; btn = 1'b1; term = 1'b1; pin = GOOD;
        tick();
        check("rst_alarm", b0.Alarma, 0);
        rst_n = 1'b1; btn = 1'b0; term = 1'b0;
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            veh   = ($urandom_range(0, 3) != 0);
            term  = ($urandom_range(0, 9) == 0);
            btn   = ($urandom_range(0, 2) == 0);
            pin   = ($urandom_range(0, 1) != 0) ? GOOD
                                                : 8'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
